// File: rtl/efm_pkg.sv
// rtl/efm_pkg.sv - shared constants and width-mask helper for the EFM stage
package efm_pkg;

  localparam int EFM_LFSR_WIDTH = 16;
  localparam logic [EFM_LFSR_WIDTH-1:0] EFM_LFSR_TAPS = 16'hB400;

  // Mask of the n low bits, with n clamped to the accumulator width w.
  function automatic logic [31:0] f_efm_mask(input logic [31:0] n, input logic [31:0] w);
    logic [31:0] ne;
    ne = (n > w) ? w : n;
    if (ne >= 32'd32) return 32'hFFFF_FFFF;
    return (32'd1 << ne) - 32'd1;
  endfunction

endpackage

// File: rtl/efm_lfsr.sv
// rtl/efm_lfsr.sv - 16-bit Galois LFSR used as the dither source
module efm_lfsr
  import efm_pkg::*;
#(
  parameter logic [EFM_LFSR_WIDTH-1:0] P_INIT = 16'hACE1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  output logic [EFM_LFSR_WIDTH-1:0] o_state
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_state <= P_INIT;
    end else if (i_en) begin
      o_state <= (o_state >> 1) ^ (o_state[0] ? EFM_LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/efm_sel_pipe.sv
// rtl/efm_sel_pipe.sv - selectable-width error-feedback modulator stage
module efm_sel_pipe
  import efm_pkg::*;
#(
  parameter int                        P_DATA_WIDTH = 8,
  parameter int                        P_SEL_WIDTH  = 4,
  parameter logic [31:0]               P_RST_SEED   = '0,
  parameter logic [EFM_LFSR_WIDTH-1:0] P_LFSR_INIT  = 16'hACE1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_SEL_WIDTH-1:0]  i_mash_bit,
  input  logic [P_DATA_WIDTH-1:0] i_seed,
  input  logic                    i_seed_load,
  input  logic                    i_valid,
  input  logic [P_DATA_WIDTH-1:0] i_efm_data,
  input  logic                    i_quantize,
  input  logic                    i_dither_en,
  output logic                    o_valid,
  output logic [P_DATA_WIDTH-1:0] o_efm_data,
  output logic                    o_quantize,
  output logic                    o_cfg_err
);

  localparam int                    W        = P_DATA_WIDTH;
  localparam logic [31:0]           W_U      = 32'(P_DATA_WIDTH);
  localparam logic [P_SEL_WIDTH-1:0] W_SEL   = P_SEL_WIDTH'(P_DATA_WIDTH);
  localparam logic [W-1:0]          RST_SEED = P_RST_SEED[W-1:0];

  logic [W-1:0]              residue;
  logic [P_SEL_WIDTH-1:0]    r_mode;
  logic [EFM_LFSR_WIDTH-1:0] lfsr_state;
  logic                      cfg_over;
  logic [P_SEL_WIDTH-1:0]    ne;
  logic [31:0]               mask32;
  logic [W-1:0]              mask;
  logic [W-1:0]              a;
  logic [W-1:0]              prev;
  logic [W:0]                sum;
  logic [W:0]                sum_shift;
  logic                      carry;
  logic                      accept;
  logic                      unused_bits;

  assign accept    = i_valid & ~i_seed_load;
  assign cfg_over  = {{(32-P_SEL_WIDTH){1'b0}}, i_mash_bit} > W_U;
  assign ne        = cfg_over ? W_SEL : i_mash_bit;
  assign mask32    = f_efm_mask(32'(ne), W_U);
  assign mask      = mask32[W-1:0];
  assign a         = (i_efm_data ^ {{(W-1){1'b0}}, i_dither_en & lfsr_state[0]}) & mask;
  // A width change flushes the residue: the seed restarts accumulation.
  assign prev      = (ne != r_mode) ? (i_seed & mask) : residue;
  assign sum       = {1'b0, a} + {1'b0, prev} + {{W{1'b0}}, i_quantize};
  assign sum_shift = sum >> ne;
  assign carry     = sum_shift[0];
  assign unused_bits = ^{mask32, lfsr_state, sum_shift};

  efm_lfsr #(
    .P_INIT (P_LFSR_INIT)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (accept),
    .o_state (lfsr_state)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      residue    <= RST_SEED;
      r_mode     <= W_SEL;
      o_valid    <= 1'b0;
      o_efm_data <= '0;
      o_quantize <= 1'b0;
      o_cfg_err  <= 1'b0;
    end else begin
      if (cfg_over) o_cfg_err <= 1'b1;
      if (i_seed_load) begin
        residue <= i_seed & mask;
        r_mode  <= ne;
        o_valid <= 1'b0;
      end else if (i_valid) begin
        o_valid <= 1'b1;
        r_mode  <= ne;
        if (ne == '0) begin
          o_efm_data <= '0;
          o_quantize <= i_quantize;
        end else begin
          residue    <= sum[W-1:0] & mask;
          o_efm_data <= sum[W-1:0] & mask;
          o_quantize <= carry;
        end
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_efm_sel_pipe.sv
// tb/tb_efm_sel_pipe.sv - directed table, corner sequences and randomized model check
module tb_efm_sel_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mash;
  logic [7:0] seed;
  logic       sl;
  logic       v;
  logic [7:0] data;
  logic       q;
  logic       dith;
  logic       ov;
  logic [7:0] od;
  logic       oq;
  logic       oerr;

  int tests = 0;
  int fails = 0;

  // Reference state kept as plain integers.
  int m_res, m_mode, m_lfsr;
  int e_v, e_d, e_q, e_err;

  efm_sel_pipe #(
    .P_DATA_WIDTH (8),
    .P_SEL_WIDTH  (4),
    .P_RST_SEED   (32'd0),
    .P_LFSR_INIT  (16'hACE1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mash_bit  (mash),
    .i_seed      (seed),
    .i_seed_load (sl),
    .i_valid     (v),
    .i_efm_data  (data),
    .i_quantize  (q),
    .i_dither_en (dith),
    .o_valid     (ov),
    .o_efm_data  (od),
    .o_quantize  (oq),
    .o_cfg_err   (oerr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mash;
    logic [7:0] seed;
    logic       sl;
    logic       v;
    logic [7:0] data;
    logic       q;
    logic       ev;
    logic [7:0] ed;
    logic       eq;
    logic       eerr;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int ne, mask, a, prev, s;
    if (rst) begin
      m_res = 0; m_mode = 8; m_lfsr = 'hACE1;
      e_v = 0; e_d = 0; e_q = 0; e_err = 0;
    end else begin
      if (mash > 8) e_err = 1;
      ne   = (mash > 8) ? 8 : int'(mash);
      mask = (1 << ne) - 1;
      if (sl) begin
        m_res  = seed & mask;
        m_mode = ne;
        e_v    = 0;
      end else if (v) begin
        e_v = 1;
        if (ne == 0) begin
          e_d = 0;
          e_q = q;
        end else begin
          a      = (data ^ ((dith && (m_lfsr % 2 == 1)) ? 1 : 0)) & mask;
          prev   = (ne != m_mode) ? (seed & mask) : m_res;
          s      = a + prev + q;
          e_q    = (s / (1 << ne)) % 2;
          m_res  = s % (1 << ne);
          e_d    = m_res;
        end
        m_mode = ne;
        m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
      end else begin
        e_v = 0;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] mb, input logic [7:0] sd, input logic s_l,
                       input logic vv, input logic [7:0] d, input logic qq, input logic di);
    mash = mb; seed = sd; sl = s_l; v = vv; data = d; q = qq; dith = di;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'd8, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);

    tbl[0]  = '{4'd8,  8'h80, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{4'd8,  8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{4'd8,  8'h80, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[3]  = '{4'd3,  8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};
    tbl[4]  = '{4'd3,  8'h00, 1'b0, 1'b1, 8'hFD, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0};
    tbl[5]  = '{4'd3,  8'h00, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[6]  = '{4'd8,  8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0};
    tbl[7]  = '{4'd0,  8'h80, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{4'd8,  8'h80, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{4'd8,  8'h80, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[10] = '{4'd8,  8'hA7, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};
    tbl[11] = '{4'd4,  8'h35, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h06, 1'b0, 1'b0};
    tbl[12] = '{4'd4,  8'h35, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0};
    tbl[13] = '{4'd12, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1};
    tbl[14] = '{4'd4,  8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1};

    step();
    step();
    chk("rst_valid", ov, 0);
    chk("rst_data", od, 0);
    chk("rst_q", oq, 0);
    chk("rst_err", oerr, 0);

    rst = 1'b0;
    drive(4'd8, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step();
    chk("rst_residue", od, 0);
    chk("rst_residue_q", oq, 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].mash, tbl[i].seed, tbl[i].sl, tbl[i].v, tbl[i].data, tbl[i].q, 1'b0);
      step();
      chk($sformatf("tbl%0d_valid", i), ov, tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), od, tbl[i].ed);
      chk($sformatf("tbl%0d_q", i), oq, tbl[i].eq);
      chk($sformatf("tbl%0d_err", i), oerr, tbl[i].eerr);
    end

    rst = 1'b1;
    drive(4'd8, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("err_cleared", oerr, 0);

    // LFSR starts at 0xACE1 (bit0=1), then 0xE270 (bit0=0).
    rst = 1'b0;
    drive(4'd8, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    step();
    chk("dither0_data", od, 8'h01);
    step();
    chk("dither1_data", od, 8'h01);
    chk("dither1_valid", ov, 1);

    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 99) < 2);
      mash = 4'($urandom_range(0, 10));
      seed = 8'($urandom);
      sl   = ($urandom_range(0, 9) == 0);
      v    = ($urandom_range(0, 9) < 7);
      data = 8'($urandom);
      q    = 1'($urandom);
      dith = 1'($urandom);
      step();
      chk($sformatf("rnd%0d_valid", i), ov, e_v);
      chk($sformatf("rnd%0d_data", i), od, e_d);
      chk($sformatf("rnd%0d_q", i), oq, e_q);
      chk($sformatf("rnd%0d_err", i), oerr, e_err);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
